// File: rtl/instr_mem_loader_if.sv
// Load-stream and fetch-side signals of the program store.
// The loader drives load_ready, instr, core_run, loaded_words and load_error.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic [31:0]       pc;
  logic [31:0]       instr;
  logic              core_run;
  logic [ADDR_W:0]   loaded_words;
  logic              load_error;

  modport master (
    output load_start, load_valid, load_byte, pc,
    input  load_ready, instr, core_run, loaded_words, load_error
  );

  modport slave (
    input  load_start, load_valid, load_byte, pc,
    output load_ready, instr, core_run, loaded_words, load_error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader + word-addressed program store feeding the fetch stage.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic clr,
  instr_mem_loader_if.slave bus
);
  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, RUN, ERROR} state_e;
`else
  typedef enum logic [2:0] {IDLE, COUNT, DATA, RUN, ERROR} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] loaded_q, loaded_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0][7:0]  bytes_q, bytes_d;
  logic [7:0]       csum_q, csum_d;
  logic             we;
  logic             accept;
  logic [8:0]       n_ext;
  logic [31:0]      mem [DEPTH];

  assign bus.load_ready   = (state_q == COUNT) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state_q == CSUM)
`endif
                            ;
  assign accept           = bus.load_valid && bus.load_ready;
  assign bus.core_run     = (state_q == RUN);
  assign bus.loaded_words = loaded_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.load_error   = (state_q == ERROR);
`else
  assign bus.load_error   = 1'b0;
`endif
  assign n_ext            = {1'b0, bus.load_byte};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    loaded_d = loaded_q;
    lane_d   = lane_q;
    bytes_d  = bytes_q;
    csum_d   = csum_q;
    we       = 1'b0;
    case (state_q)
      COUNT: if (accept) begin
        // zero or oversize count means "fill the whole store"
        if (bus.load_byte == 8'd0 || n_ext > 9'(DEPTH)) count_d = CNT_W'(DEPTH);
        else                                             count_d = n_ext[ADDR_W:0];
        state_d = DATA;
      end
      DATA: if (accept) begin
        csum_d = csum_q ^ bus.load_byte;
        if (lane_q == 2'd3) begin
          we     = 1'b1;
          lane_d = 2'd0;
          wptr_d = wptr_q + 1'b1;
          if (wptr_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d  = CSUM;
`else
            state_d  = RUN;
            loaded_d = count_q;
`endif
          end
        end else begin
          bytes_d[lane_q] = bus.load_byte;
          lane_d          = lane_q + 2'd1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) begin
        if (bus.load_byte == csum_q) begin
          state_d  = RUN;
          loaded_d = count_q;
        end else begin
          state_d  = ERROR;
        end
      end
`endif
      default: if (bus.load_start) begin
        state_d  = COUNT;
        wptr_d   = '0;
        lane_d   = '0;
        csum_d   = '0;
        loaded_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wptr_q   <= '0;
      loaded_q <= '0;
      lane_q   <= '0;
      bytes_q  <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      loaded_q <= loaded_d;
      lane_q   <= lane_d;
      bytes_q  <= bytes_d;
      csum_q   <= csum_d;
    end
  end

  // Storage is never cleared; clr only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (we && !clr) mem[wptr_q[ADDR_W-1:0]] <= {bus.load_byte, bytes_q[2], bytes_q[1], bytes_q[0]};
  end

  assign bus.instr = (bus.core_run && (bus.pc < 32'(loaded_q))) ? mem[bus.pc[ADDR_W-1:0]] : NOP;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, streaming, gapped load,
// full-depth load, mid-load reset and start/valid collisions.
module tb_instr_mem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  instr_mem_loader_if #(.ADDR_W(6)) bus ();

  instr_mem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] p, input logic [31:0] exp);
    bus.pc = p;
    #1;
    chk(tag, bus.instr, exp);
  endtask

  logic [7:0] prog [9];

  initial begin
    prog = '{8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    clr = 1'b1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte  = 8'h00;
    bus.pc         = 32'd0;
    tick(); tick();
    clr = 1'b0;
    tick();

    // reset state
    rd("rst_instr", 32'd0, NOP);
    chk("rst_run",    32'(bus.core_run), 32'd0);
    chk("rst_ready",  32'(bus.load_ready), 32'd0);
    chk("rst_words",  32'(bus.loaded_words), 32'd0);
    chk("rst_err",    32'(bus.load_error), 32'd0);

    // back-to-back stream
    start();
    chk("start_ready", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < 8; i++) send(prog[i]);
    chk("pre_last_run", 32'(bus.core_run), 32'd0);
    send(prog[8]);
`ifdef LOADER_CHECKSUM_EN
    chk("pre_csum_run", 32'(bus.core_run), 32'd0);
    send(8'hB0);
`endif
    chk("b2b_run",   32'(bus.core_run), 32'd1);
    chk("b2b_words", 32'(bus.loaded_words), 32'd2);
    chk("b2b_ready", 32'(bus.load_ready), 32'd0);
    chk("b2b_err",   32'(bus.load_error), 32'd0);
    rd("b2b_pc0", 32'd0, 32'h0010_0513);
    rd("b2b_pc1", 32'd1, 32'h0020_0593);
    rd("b2b_pc2", 32'd2, NOP);
    rd("b2b_hi",  32'h0000_0040, NOP);

    // bytes in RUN are dropped
    for (int i = 0; i < 3; i++) send(8'hFF);
    chk("run_words", 32'(bus.loaded_words), 32'd2);
    chk("run_run",   32'(bus.core_run), 32'd1);
    rd("run_pc0", 32'd0, 32'h0010_0513);
    rd("run_pc1", 32'd1, 32'h0020_0593);

    // gapped stream
    start();
    chk("gap_run0", 32'(bus.core_run), 32'd0);
    rd("gap_nop", 32'd0, NOP);
    for (int i = 0; i < 9; i++) begin
      tick();
      send(prog[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    tick();
    send(8'hB0);
`endif
    chk("gap_run",   32'(bus.core_run), 32'd1);
    chk("gap_words", 32'(bus.loaded_words), 32'd2);
    rd("gap_pc0", 32'd0, 32'h0010_0513);
    rd("gap_pc1", 32'd1, 32'h0020_0593);
    rd("gap_pc2", 32'd2, NOP);

    // count 0 -> full depth, byte j = j
    start();
    send(8'h00);
    for (int j = 0; j < 255; j++) send(8'(j));
    chk("full_ready_pre", 32'(bus.load_ready), 32'd1);
    chk("full_run_pre",   32'(bus.core_run), 32'd0);
    send(8'hFF);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("full_run",   32'(bus.core_run), 32'd1);
    chk("full_words", 32'(bus.loaded_words), 32'd64);
    rd("full_pc0",  32'd0,  32'h0302_0100);
    rd("full_pc63", 32'd63, 32'hFFFE_FDFC);
    rd("full_pc64", 32'd64, NOP);

    // reset after 5 data bytes, then reload one word
    start();
    send(8'h02);
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_run",   32'(bus.core_run), 32'd0);
    chk("clr_ready", 32'(bus.load_ready), 32'd0);
    chk("clr_words", 32'(bus.loaded_words), 32'd0);
    rd("clr_nop", 32'd0, NOP);
    start();
    send(8'h01);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send(8'h22);
`endif
    chk("one_words", 32'(bus.loaded_words), 32'd1);
    rd("one_pc0", 32'd0, 32'hDEAD_BEEF);
    rd("one_pc1", 32'd1, NOP);

    // clr wins over load_start
    bus.load_start = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.load_start = 1'b0;
    chk("clr_vs_start", 32'(bus.load_ready), 32'd0);

    // start with valid in IDLE: byte not taken as count
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h03;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    chk("sv_ready", 32'(bus.load_ready), 32'd1);
    send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef LOADER_CHECKSUM_EN
    send(8'h44);
`endif
    chk("sv_words", 32'(bus.loaded_words), 32'd1);
    rd("sv_pc0", 32'd0, 32'h4433_2211);

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum
    start();
    for (int i = 0; i < 9; i++) send(prog[i]);
    send(8'h00);
    chk("cs_err", 32'(bus.load_error), 32'd1);
    chk("cs_run", 32'(bus.core_run), 32'd0);
    rd("cs_nop", 32'd0, NOP);
    start();
    chk("cs_clear", 32'(bus.load_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
